// File: rtl/twos_comp_pkg.sv
// twos_comp_pkg: shared mode encodings, FSM state type and helpers
// for the sequential two's-complement unit (twos_comp_seq).
package twos_comp_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Negate, or absolute value of a negative operand, both become
    // "invert every bit and add one".
    function automatic logic is_invert(logic [1:0] mode, logic sign);
        return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
    endfunction

endpackage

// File: rtl/twos_slice_rca.sv
// twos_slice_rca: SLICE-bit ripple-carry adder.
// Ports: a, b (addends), cin (carry in) -> s (sum), cout (carry out).
module twos_slice_rca #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/twos_comp_seq.sv
// twos_comp_seq: pass / negate / abs of a WIDTH-bit two's-complement
// operand, SLICE bits per clock, LSB slice first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_mode
// operand handshake; out_valid/out_ready/out_data/out_ovf result.
// Macro TWOS_COMP_SAT_EN: saturate an overflowing result to 0111..1.
module twos_comp_seq
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);
    localparam logic [WIDTH-1:0] MIN_VAL =
        {1'b1, {(WIDTH-1){1'b0}}};

`ifdef TWOS_COMP_SAT_EN
    localparam logic [WIDTH-1:0] OVF_VAL =
        {1'b0, {(WIDTH-1){1'b1}}};
`else
    localparam logic [WIDTH-1:0] OVF_VAL = MIN_VAL;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [IW-1:0]    idx;
    logic             invert;
    logic             carry;
    logic             ovf_q;
    logic             inv_in;
    logic             accept;
    logic             last;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_s;
    logic             sl_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign inv_in = is_invert(in_mode, in_data[WIDTH-1]);
    assign accept = in_valid & in_ready;
    assign last   = (state == ST_RUN) && (idx == LAST_IDX);

    // The operand shifts right so the current slice is always at the
    // bottom; results enter the accumulator from the top.
    assign sl_a    = opnd[SLICE-1:0] ^ {SLICE{invert}};
    assign acc_nxt = WIDTH'({sl_s, acc} >> SLICE);

    twos_slice_rca #(
        .SLICE (SLICE)
    ) u_rca (
        .a    (sl_a),
        .b    ('0),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd     <= '0;
            acc      <= '0;
            idx      <= '0;
            invert   <= 1'b0;
            carry    <= 1'b0;
            ovf_q    <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            opnd   <= in_data;
            invert <= inv_in;
            carry  <= inv_in;
            idx    <= '0;
            ovf_q  <= inv_in && (in_data == MIN_VAL);
        end else if (state == ST_RUN) begin
            opnd  <= opnd >> SLICE;
            acc   <= acc_nxt;
            carry <= sl_cout;
            idx   <= idx + 1'b1;
            // Results only move to the outputs on completion, so they
            // stay steady while the next operand is being worked on.
            if (last) begin
                out_data <= ovf_q ? OVF_VAL : acc_nxt;
                out_ovf  <= ovf_q;
            end
        end
    end

endmodule
